// File: rtl/jt89_bus_ctrl_pkg.sv
// Shared definitions for the JT89 CPU write decoder: byte field positions,
// channel codes, reset constants and the enums used by the write path and wait timer.
package jt89_bus_ctrl_pkg;

  localparam int LATCH_BIT = 7;
  localparam int CH_MSB    = 6;
  localparam int CH_LSB    = 5;
  localparam int TYPE_BIT  = 4;

  localparam logic [1:0] CH_NOISE = 2'd3;
  localparam logic [3:0] VOL_MUTE = 4'hF;

  typedef enum logic {
    LT_TONE = 1'b0,
    LT_VOL  = 1'b1
  } latch_type_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

  function automatic logic is_latch_byte(input logic [7:0] b);
    return b[LATCH_BIT];
  endfunction

endpackage

// File: rtl/jt89_wait.sv
// READY wait-state timer: after a start pulse, holds ready low for WAIT_CYCLES
// clock-enable ticks, then releases it on the tick where the count reaches one.
module jt89_wait
  import jt89_bus_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  input  logic start,
  output logic ready
);

  localparam logic [7:0] LOAD_VAL = 8'(WAIT_CYCLES);

  wait_state_e state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic        ready_r, ready_s;

  // State, counter and ready flop
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= ready_s;
    end
  end

  // Next-state logic; the counter never decrements below one so it cannot wrap
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    ready_s = ready_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_WAIT;
          cnt_s   = LOAD_VAL;
          ready_s = 1'b0;
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_WAIT: begin
        if (clk_en) begin
          if (cnt_r == 8'd1) begin
            state_s = ST_IDLE;
            ready_s = 1'b1;
          end else begin
            cnt_s = cnt_r - 8'd1;
          end
        end else begin
          ready_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_IDLE;
        ready_s = 1'b1;
      end
    endcase
  end

  assign ready = ready_r;

endmodule

// File: rtl/jt89_bus_ctrl.sv
// JT89 CPU-side write decoder: detects SN76489 latch/data byte writes, holds the
// tone/volume/noise register file and drives the READY wait-state handshake.
module jt89_bus_ctrl
  import jt89_bus_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       noise_rst
);

  logic        act_s, act_d1_r, act_d2_r, wr_stb_s, accept_s;
  logic [7:0]  din_r;
  logic [9:0]  tone_r [3];
  logic [3:0]  vol_r  [4];
  logic [2:0]  ctrl3_r;
  logic        noise_rst_r;
  logic [1:0]  latch_ch_r, tgt_ch_s;
  latch_type_e latch_type_r, tgt_type_s;
  logic        is_latch_s;

  assign act_s    = ~cs_n & ~wr_n;
  assign wr_stb_s = act_d1_r & ~act_d2_r;
  assign accept_s = wr_stb_s & ready;

  // Write-strobe edge detector at full clock rate
  always_ff @(posedge clk) begin
    if (rst) begin
      act_d1_r <= 1'b0;
      act_d2_r <= 1'b0;
      din_r    <= 8'd0;
    end else begin
      act_d1_r <= act_s;
      act_d2_r <= act_d1_r;
      din_r    <= din;
    end
  end

  // A latch byte carries its own target; a data byte reuses the stored latch
  always_comb begin
    is_latch_s = is_latch_byte(din_r);
    if (is_latch_s) begin
      tgt_ch_s   = din_r[CH_MSB:CH_LSB];
      tgt_type_s = latch_type_e'(din_r[TYPE_BIT]);
    end else begin
      tgt_ch_s   = latch_ch_r;
      tgt_type_s = latch_type_r;
    end
  end

  // Register file update on an accepted strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) tone_r[i] <= 10'd0;
      for (int i = 0; i < 4; i++) vol_r[i] <= VOL_MUTE;
      ctrl3_r      <= 3'd0;
      noise_rst_r  <= 1'b0;
      latch_ch_r   <= 2'd0;
      latch_type_r <= LT_TONE;
    end else begin
      noise_rst_r <= 1'b0;
      if (accept_s) begin
        if (is_latch_s) begin
          latch_ch_r   <= tgt_ch_s;
          latch_type_r <= tgt_type_s;
        end
        if (tgt_type_s == LT_VOL) begin
          vol_r[tgt_ch_s] <= din_r[3:0];
        end else if (tgt_ch_s == CH_NOISE) begin
          ctrl3_r     <= din_r[2:0];
          noise_rst_r <= 1'b1;
        end else if (is_latch_s) begin
          tone_r[tgt_ch_s][3:0] <= din_r[3:0];
        end else begin
          tone_r[tgt_ch_s][9:4] <= din_r[5:0];
        end
      end
    end
  end

  jt89_wait #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .start  (accept_s),
    .ready  (ready)
  );

  assign tone0     = tone_r[0];
  assign tone1     = tone_r[1];
  assign tone2     = tone_r[2];
  assign vol0      = vol_r[0];
  assign vol1      = vol_r[1];
  assign vol2      = vol_r[2];
  assign vol3      = vol_r[3];
  assign ctrl3     = ctrl3_r;
  assign noise_rst = noise_rst_r;

endmodule

// File: tb/tb_jt89_bus_ctrl.sv
// Directed bench for jt89_bus_ctrl: byte writes with hand-computed register
// values, READY wait length in clk_en ticks, noise_rst pulses, ignored strobes and reset.
module tb_jt89_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       cs_n = 1'b1;
  logic       wr_n = 1'b1;
  logic [7:0] din = 8'd0;
  logic       ready, noise_rst;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;

  int checks = 0;
  int errors = 0;
  int nr_cnt = 0;

  jt89_bus_ctrl #(.WAIT_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .cs_n(cs_n), .wr_n(wr_n), .din(din),
    .ready(ready), .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3),
    .ctrl3(ctrl3), .noise_rst(noise_rst)
  );

  always #5 clk = ~clk;

  // clk_en: one clock high every 16 clocks
  initial begin
    forever begin
      repeat (15) @(negedge clk);
      clk_en = 1'b1;
      @(negedge clk);
      clk_en = 1'b0;
    end
  end

  // Count clocks with noise_rst high
  always @(negedge clk) if (noise_rst === 1'b1) nr_cnt <= nr_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one write held for 'hold' clocks, optionally inject a second strobe at
  // clock inj_at, and measure READY low time, ticks while low and any re-drop.
  task automatic run_write(input logic [7:0] d, input int hold, input int inj_at,
                           input logic [7:0] inj_d, output int low_cyc,
                           output int ticks, output int relow);
    bit returned = 1'b0;
    bit done = 1'b0;
    low_cyc = 0; ticks = 0; relow = 0;
    @(negedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; din = d;
    for (int i = 1; i <= 3000 && !done; i++) begin
      @(negedge clk); #1;
      if (i == hold) begin cs_n = 1'b1; wr_n = 1'b1; end
      if (inj_at > 0 && i == inj_at) begin cs_n = 1'b0; wr_n = 1'b0; din = inj_d; end
      if (inj_at > 0 && i == inj_at + 1) begin cs_n = 1'b1; wr_n = 1'b1; end
      if (ready === 1'b0) begin
        if (returned) relow++;
        else begin
          low_cyc++;
          if (clk_en === 1'b1) ticks++;
        end
      end else if (low_cyc > 0) begin
        returned = 1'b1;
      end
      if (returned && i >= hold + 5 && i >= inj_at + 5) done = 1'b1;
    end
    chk("write_completes", {31'd0, done}, 32'd1);
  endtask

  int lc, tk, rl, n0;

  initial begin
    // Reset
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_tone0", {22'd0, tone0}, 32'd0);
    chk("rst_tone1", {22'd0, tone1}, 32'd0);
    chk("rst_tone2", {22'd0, tone2}, 32'd0);
    chk("rst_vol0", {28'd0, vol0}, 32'hF);
    chk("rst_vol1", {28'd0, vol1}, 32'hF);
    chk("rst_vol2", {28'd0, vol2}, 32'hF);
    chk("rst_vol3", {28'd0, vol3}, 32'hF);
    chk("rst_ctrl3", {29'd0, ctrl3}, 32'd0);
    chk("rst_noise_rst", {31'd0, noise_rst}, 32'd0);

    // Tone 0 latch then data byte; 32 ticks ~ 512 clk each
    run_write(8'h8E, 1, 0, 8'h00, lc, tk, rl);
    chk("t0_lo", {22'd0, tone0}, 32'h00E);
    chk("t0_lo_ticks", tk, 32'd32);
    chk("t0_lo_lowlen", {31'd0, (lc >= 496 && lc <= 528)}, 32'd1);
    run_write(8'h0F, 1, 0, 8'h00, lc, tk, rl);
    chk("t0_full", {22'd0, tone0}, 32'h0FE);
    chk("t0_full_ticks", tk, 32'd32);
    chk("t0_full_lowlen", {31'd0, (lc >= 496 && lc <= 528)}, 32'd1);

    // Volume 2 latch, then data byte through the held latch
    run_write(8'hD5, 1, 0, 8'h00, lc, tk, rl);
    chk("vol2_latch", {28'd0, vol2}, 32'h5);
    run_write(8'h0A, 1, 0, 8'h00, lc, tk, rl);
    chk("vol2_data", {28'd0, vol2}, 32'hA);
    chk("tone2_untouched", {22'd0, tone2}, 32'd0);

    // Noise control: latch and data both pulse noise_rst for one clock
    n0 = nr_cnt;
    run_write(8'hE6, 1, 0, 8'h00, lc, tk, rl);
    chk("ctrl3_latch", {29'd0, ctrl3}, 32'b110);
    chk("nrst_pulse1", nr_cnt - n0, 32'd1);
    n0 = nr_cnt;
    run_write(8'h03, 1, 0, 8'h00, lc, tk, rl);
    chk("ctrl3_data", {29'd0, ctrl3}, 32'b011);
    chk("nrst_pulse2", nr_cnt - n0, 32'd1);
    chk("tone0_kept", {22'd0, tone0}, 32'h0FE);

    // Strobe while busy is ignored: no vol0 change, latch kept, no reload
    run_write(8'hB7, 1, 50, 8'h9F, lc, tk, rl);
    chk("busy_vol1", {28'd0, vol1}, 32'h7);
    chk("busy_ticks", tk, 32'd32);
    run_write(8'h02, 1, 0, 8'h00, lc, tk, rl);
    chk("busy_latch_kept", {28'd0, vol1}, 32'h2);
    chk("busy_vol0", {28'd0, vol0}, 32'hF);

    // Long strobe held past the wait: exactly one write
    run_write(8'h8C, 600, 0, 8'h00, lc, tk, rl);
    chk("long_tone0", {22'd0, tone0}, 32'h0FC);
    chk("long_ticks", tk, 32'd32);
    chk("long_no_rewrite", rl, 32'd0);

    // Reset in the middle of a wait
    @(negedge clk); #1;
    cs_n = 1'b0; wr_n = 1'b0; din = 8'hA5;
    @(negedge clk); #1;
    cs_n = 1'b1; wr_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("mid_ready_low", {31'd0, ready}, 32'd0);
    chk("mid_tone1", {22'd0, tone1}, 32'h005);
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_ready", {31'd0, ready}, 32'd1);
    chk("mid_rst_tone1", {22'd0, tone1}, 32'd0);
    chk("mid_rst_vol1", {28'd0, vol1}, 32'hF);
    chk("mid_rst_vol2", {28'd0, vol2}, 32'hF);
    run_write(8'h3F, 1, 0, 8'h00, lc, tk, rl);
    chk("post_rst_tone0", {22'd0, tone0}, 32'h3F0);
    chk("post_rst_tone1", {22'd0, tone1}, 32'd0);
    chk("post_rst_ticks", tk, 32'd32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
